// File: rtl/common_split_buffer2_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : common_split_buffer2_pkg                                     |
// | Description : Shared types and constants for the 1-to-2 split buffer.      |
// |               COMMON_SPLIT_BUFFER2_BROADCAST_EN widens the destination to  |
// |               a 2-bit one-hot target mask; otherwise it is a port index.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package common_split_buffer2_pkg;

`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
    localparam int DST_WIDTH = 2;
`else
    localparam int DST_WIDTH = 1;
`endif

    typedef logic [DST_WIDTH-1:0] dst_t;

    // Port index encoding (non-broadcast build)
    localparam logic DST_PORT0 = 1'b0;
    localparam logic DST_PORT1 = 1'b1;

    // Target mask encoding (broadcast build)
    localparam logic [1:0] DST_MASK_P0  = 2'b01;
    localparam logic [1:0] DST_MASK_P1  = 2'b10;
    localparam logic [1:0] DST_MASK_ALL = 2'b11;

endpackage

`default_nettype wire

// File: rtl/common_bypass_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : common_bypass_buffer                                         |
// | Description : One-entry bypass buffer. When empty, the upstream beat goes  |
// |               straight through; if downstream is not ready it is captured. |
// |               Upstream ready comes only from the registered full flag.     |
// | Ports       : clk, reset, prev_i_data/prev_i_valid/prev_o_ready (upstream),|
// |               next_o_data/next_o_valid/next_i_ready (downstream).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module common_bypass_buffer #(
    parameter int BUFFER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next_o_data,
    output logic                    next_o_valid,
    input  logic                    next_i_ready
);

    logic                    r_full;
    logic [BUFFER_WIDTH-1:0] r_data;
    logic                    w_capture;

    assign w_capture = ~r_full & prev_i_valid & ~next_i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (r_full) begin
            if (next_i_ready) begin
                r_full <= 1'b0;
            end
        end else if (w_capture) begin
            r_full <= 1'b1;
        end
    end

    // Payload register carries no reset; r_full qualifies it.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_data <= prev_i_data;
        end
    end

    // Outputs held at zero while reset is asserted.
    assign prev_o_ready = ~reset & ~r_full;
    assign next_o_valid = ~reset & (r_full | prev_i_valid);
    assign next_o_data  = reset  ? '0 : (r_full ? r_data : prev_i_data);

endmodule

`default_nettype wire

// File: rtl/stdmacro_dffe.sv
// +----------------------------------------------------------------------------+
// | Module      : stdmacro_dffe                                                |
// | Description : Enabled D flip-flop bank with synchronous active-high reset. |
// | Ports       : clk, reset, i_en (load enable), i_d (next value), o_q.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module stdmacro_dffe #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/common_split_buffer2.sv
// +----------------------------------------------------------------------------+
// | Module      : common_split_buffer2                                         |
// | Description : 1-to-2 split buffer. Each beat is routed to port 0 or port 1 |
// |               by prev_i_dst; each port has its own bypass buffer so one    |
// |               stalled port does not block the other.                       |
// |               Macro COMMON_SPLIT_BUFFER2_BROADCAST_EN: prev_i_dst becomes a|
// |               target mask; per-port done bits avoid re-sending a beat.     |
// | Ports       : clk, reset, prev_i_* (upstream), next0_* / next1_* (outputs).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module common_split_buffer2
    import common_split_buffer2_pkg::*;
#(
    parameter int BUFFER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic [DST_WIDTH-1:0]    prev_i_dst,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next0_o_data,
    output logic                    next0_o_valid,
    input  logic                    next0_i_ready,
    output logic [BUFFER_WIDTH-1:0] next1_o_data,
    output logic                    next1_o_valid,
    input  logic                    next1_i_ready
);

    logic [1:0]              w_tgt;
    logic [1:0]              w_done;
    logic [1:0]              w_req;
    logic [1:0]              w_acc;
    logic [1:0]              w_ok;
    logic [1:0]              w_nready;
    logic [1:0]              w_nvalid;
    logic [BUFFER_WIDTH-1:0] w_ndata [2];

`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
    logic [1:0] w_done_d;

    assign w_tgt = prev_i_dst;

    // Whole-beat acceptance clears done; otherwise remember ports that took it.
    assign w_done_d = prev_o_ready ? 2'b00 : (w_done | (w_req & w_acc));

    stdmacro_dffe #(
        .WIDTH     (2),
        .RESET_VAL (2'b00)
    ) u_done (
        .clk   (clk),
        .reset (reset),
        .i_en  (prev_i_valid),
        .i_d   (w_done_d),
        .o_q   (w_done)
    );
`else
    assign w_tgt  = {prev_i_dst == DST_PORT1, prev_i_dst == DST_PORT0};
    assign w_done = 2'b00;
`endif

    assign w_nready = {next1_i_ready, next0_i_ready};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_port
            assign w_req[k] = prev_i_valid & w_tgt[k] & ~w_done[k];
            // Port is satisfied if untargeted, already served, or accepting now.
            assign w_ok[k]  = ~w_tgt[k] | w_done[k] | w_acc[k];

            common_bypass_buffer #(
                .BUFFER_WIDTH (BUFFER_WIDTH)
            ) u_buf (
                .clk          (clk),
                .reset        (reset),
                .prev_i_data  (prev_i_data),
                .prev_i_valid (w_req[k]),
                .prev_o_ready (w_acc[k]),
                .next_o_data  (w_ndata[k]),
                .next_o_valid (w_nvalid[k]),
                .next_i_ready (w_nready[k])
            );
        end
    endgenerate

    assign prev_o_ready  = ~reset & (&w_ok);
    assign next0_o_data  = w_ndata[0];
    assign next0_o_valid = w_nvalid[0];
    assign next1_o_data  = w_ndata[1];
    assign next1_o_valid = w_nvalid[1];

endmodule

`default_nettype wire

// File: tb/tb_common_split_buffer2.sv
`default_nettype none

module tb_common_split_buffer2;
    import common_split_buffer2_pkg::*;

    localparam int W = 8;

`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
    localparam dst_t TB_DST0 = DST_MASK_P0;
    localparam dst_t TB_DST1 = DST_MASK_P1;
`else
    localparam dst_t TB_DST0 = DST_PORT0;
    localparam dst_t TB_DST1 = DST_PORT1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] prev_i_data;
    dst_t         prev_i_dst;
    logic         prev_i_valid;
    logic         prev_o_ready;
    logic [W-1:0] next0_o_data;
    logic         next0_o_valid;
    logic         next0_i_ready;
    logic [W-1:0] next1_o_data;
    logic         next1_o_valid;
    logic         next1_i_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    common_split_buffer2 #(.BUFFER_WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .prev_i_data   (prev_i_data),
        .prev_i_dst    (prev_i_dst),
        .prev_i_valid  (prev_i_valid),
        .prev_o_ready  (prev_o_ready),
        .next0_o_data  (next0_o_data),
        .next0_o_valid (next0_o_valid),
        .next0_i_ready (next0_i_ready),
        .next1_o_data  (next1_o_data),
        .next1_o_valid (next1_o_valid),
        .next1_i_ready (next1_i_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; prev_i_valid = 1'b0; prev_i_data = '0; prev_i_dst = TB_DST0;
        next0_i_ready = 1'b1; next1_i_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (prev_o_ready !== 1'b0 || next0_o_valid !== 1'b0 || next1_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_during: ready=%b v0=%b v1=%b, required 0 0 0", prev_o_ready, next0_o_valid, next1_o_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (prev_o_ready !== 1'b1 || next0_o_valid !== 1'b0 || next1_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: ready=%b v0=%b v1=%b, required 1 0 0", prev_o_ready, next0_o_valid, next1_o_valid);
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            prev_i_valid = 1'b1;
            prev_i_data  = W'(i + 1);
            prev_i_dst   = (i % 2 == 0) ? TB_DST0 : TB_DST1;
            #1;
            n_checks++;
            if (prev_o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL alt_ready[%0d]: got %b, required 1", i, prev_o_ready);
            end
            n_checks++;
            if (i % 2 == 0) begin
                if (next0_o_valid !== 1'b1 || next0_o_data !== W'(i + 1) || next1_o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL alt_port0[%0d]: v0=%b d0=%h v1=%b, required 1 %h 0", i, next0_o_valid, next0_o_data, next1_o_valid, W'(i + 1));
                end
            end else begin
                if (next1_o_valid !== 1'b1 || next1_o_data !== W'(i + 1) || next0_o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL alt_port1[%0d]: v1=%b d1=%h v0=%b, required 1 %h 0", i, next1_o_valid, next1_o_data, next0_o_valid, W'(i + 1));
                end
            end
            tick();
        end
        prev_i_valid = 1'b0;
    endtask

    task automatic test_stall_and_drain();
        next0_i_ready = 1'b0; next1_i_ready = 1'b1;
        prev_i_valid = 1'b1; prev_i_dst = TB_DST0; prev_i_data = 8'h0A;
        #1;
        n_checks++;
        if (prev_o_ready !== 1'b1 || next0_o_valid !== 1'b1 || next0_o_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL stall_a: ready=%b v0=%b d0=%h, required 1 1 0a", prev_o_ready, next0_o_valid, next0_o_data);
        end
        tick();
        prev_i_dst = TB_DST1; prev_i_data = 8'h0B;
        #1;
        n_checks++;
        if (prev_o_ready !== 1'b1 || next1_o_valid !== 1'b1 || next1_o_data !== 8'h0B
            || next0_o_valid !== 1'b1 || next0_o_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL stall_b: ready=%b v1=%b d1=%h v0=%b d0=%h, required 1 1 0b 1 0a",
                     prev_o_ready, next1_o_valid, next1_o_data, next0_o_valid, next0_o_data);
        end
        tick();
        prev_i_dst = TB_DST0; prev_i_data = 8'h0C;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (prev_o_ready !== 1'b0 || next0_o_data !== 8'h0A || next1_o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_c[%0d]: ready=%b d0=%h v1=%b, required 0 0a 0", c, prev_o_ready, next0_o_data, next1_o_valid);
            end
            tick();
        end
        // Drain: ready rises while 0xC pending; acceptance waits one cycle.
        next0_i_ready = 1'b1;
        #1;
        n_checks++;
        if (prev_o_ready !== 1'b0 || next0_o_valid !== 1'b1 || next0_o_data !== 8'h0A) begin
            n_fail++;
            $display("FAIL drain_a: ready=%b v0=%b d0=%h, required 0 1 0a", prev_o_ready, next0_o_valid, next0_o_data);
        end
        tick();
        n_checks++;
        if (prev_o_ready !== 1'b1 || next0_o_valid !== 1'b1 || next0_o_data !== 8'h0C) begin
            n_fail++;
            $display("FAIL drain_c: ready=%b v0=%b d0=%h, required 1 1 0c", prev_o_ready, next0_o_valid, next0_o_data);
        end
        tick();
        prev_i_valid = 1'b0;
        #1;
        n_checks++;
        if (next0_o_valid !== 1'b0 || next1_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: v0=%b v1=%b, required 0 0", next0_o_valid, next1_o_valid);
        end
    endtask

    task automatic test_reset_full();
        next0_i_ready = 1'b0; next1_i_ready = 1'b0;
        prev_i_valid = 1'b1; prev_i_dst = TB_DST0; prev_i_data = 8'h11;
        tick();
        prev_i_dst = TB_DST1; prev_i_data = 8'h22;
        tick();
        prev_i_valid = 1'b0;
        #1;
        n_checks++;
        if (next0_o_valid !== 1'b1 || next0_o_data !== 8'h11 || next1_o_valid !== 1'b1 || next1_o_data !== 8'h22) begin
            n_fail++;
            $display("FAIL rfull_fill: v0=%b d0=%h v1=%b d1=%h, required 1 11 1 22", next0_o_valid, next0_o_data, next1_o_valid, next1_o_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; next0_i_ready = 1'b1; next1_i_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (next0_o_valid !== 1'b0 || next1_o_valid !== 1'b0 || prev_o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rfull_after[%0d]: v0=%b v1=%b ready=%b, required 0 0 1", c, next0_o_valid, next1_o_valid, prev_o_ready);
            end
            tick();
        end
    endtask

`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
    task automatic test_broadcast();
        int cnt0 = 0;
        // Pre-fill port 1 so it cannot accept the broadcast beat.
        next0_i_ready = 1'b1; next1_i_ready = 1'b0;
        prev_i_valid = 1'b1; prev_i_dst = DST_MASK_P1; prev_i_data = 8'h77;
        tick();
        prev_i_dst = DST_MASK_ALL; prev_i_data = 8'h55;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) next1_i_ready = 1'b1;
            #1;
            if (next0_o_valid && next0_i_ready && next0_o_data == 8'h55) cnt0++;
            n_checks++;
            if (c == 0) begin
                if (prev_o_ready !== 1'b0 || next0_o_valid !== 1'b1 || next0_o_data !== 8'h55) begin
                    n_fail++;
                    $display("FAIL bc_c0: ready=%b v0=%b d0=%h, required 0 1 55", prev_o_ready, next0_o_valid, next0_o_data);
                end
            end else if (c < 4) begin
                if (prev_o_ready !== 1'b0 || next0_o_valid !== 1'b0 || next1_o_data !== 8'h77) begin
                    n_fail++;
                    $display("FAIL bc_wait[%0d]: ready=%b v0=%b d1=%h, required 0 0 77", c, prev_o_ready, next0_o_valid, next1_o_data);
                end
            end else begin
                if (prev_o_ready !== 1'b1 || next1_o_valid !== 1'b1 || next1_o_data !== 8'h55 || next0_o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bc_done: ready=%b v1=%b d1=%h v0=%b, required 1 1 55 0", prev_o_ready, next1_o_valid, next1_o_data, next0_o_valid);
                end
            end
            tick();
        end
        n_checks++;
        if (cnt0 != 1) begin
            n_fail++;
            $display("FAIL bc_once: port0 deliveries=%0d, required 1", cnt0);
        end
        // done must be back to 00: a fresh port0 beat goes straight through.
        prev_i_dst = DST_MASK_P0; prev_i_data = 8'h66;
        #1;
        n_checks++;
        if (prev_o_ready !== 1'b1 || next0_o_valid !== 1'b1 || next0_o_data !== 8'h66) begin
            n_fail++;
            $display("FAIL bc_clear: ready=%b v0=%b d0=%h, required 1 1 66", prev_o_ready, next0_o_valid, next0_o_data);
        end
        tick();
        prev_i_dst = 2'b00; prev_i_data = 8'h99;
        #1;
        n_checks++;
        if (prev_o_ready !== 1'b1 || next0_o_valid !== 1'b0 || next1_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bc_mask0: ready=%b v0=%b v1=%b, required 1 0 0", prev_o_ready, next0_o_valid, next1_o_valid);
        end
        tick();
        prev_i_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_stall_and_drain();
        test_reset_full();
`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
        test_broadcast();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
